uart_hex_sender: RTL and testbench



---
 rtl/uart_hex_sender_if.sv | 11 +
 rtl/uart_hex_sender.sv | 176 +++++++++++++++++
 tb/tb_uart_hex_sender.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_hex_sender_if.sv
// Byte stream from uart_hex_sender (master) to the UART transmit serializer (slave).
// A byte moves on a rising edge where tx_valid && tx_ready. While tx_valid is high and
// the byte has not moved, tx_data holds. tx_ready carries no meaning while tx_valid is low.
interface uart_hex_sender_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_hex_sender.sv
// Renders a 64-bit (or 32-bit) word as lowercase ASCII hex text into a byte FIFO for the UART.
// Optional macro UART_HEX_CRLF_EN: records end in CR LF instead of LF alone.
module uart_hex_sender #(
  parameter int unsigned FIFO_AW = 5  // must be >= 5 so a whole record always fits
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdata_snd_start,
  input  logic [63:0]       rdata_snd,
  input  logic              pc_print_sel,
  uart_hex_sender_if.master tx,
  output logic              flushing_wq,
  output logic              snd_busy,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  localparam int unsigned      DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  // Record positions are counted on the 64-bit layout: 0-7 upper word, 8 space,
  // 9-16 lower word, then the terminator. 32-bit records start at position 9.
`ifdef UART_HEX_CRLF_EN
  localparam logic [4:0] LAST_VIDX = 5'd18;
`else
  localparam logic [4:0] LAST_VIDX = 5'd17;
`endif

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [63:0]        data_q, data_d;
  logic               sel_q, sel_d;
  logic               overrun_q, overrun_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         mem_q [DEPTH];

  logic        push;
  logic        pop;
  logic        full;
  logic        tx_valid_w;
  logic [4:0]  vidx;
  logic [4:0]  lo_pos;
  logic [2:0]  npos;
  logic [31:0] word;
  logic [31:0] word_sh;
  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic [7:0]  char_byte;

  // Character generator for the current record position
  always_comb begin
    vidx      = sel_q ? (cnt_q + 5'd9) : cnt_q;
    lo_pos    = vidx - 5'd9;
    npos      = (vidx < 5'd8) ? vidx[2:0] : lo_pos[2:0];
    word      = (vidx < 5'd8) ? data_q[63:32] : data_q[31:0];
    word_sh   = word >> (5'd28 - {npos, 2'b00});
    nibble    = word_sh[3:0];
    hex_char  = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h57 + {4'h0, nibble});
    char_byte = hex_char;
    if (vidx == 5'd8) begin
      char_byte = 8'h20;
    end else if (vidx == LAST_VIDX) begin
      char_byte = 8'h0a;
`ifdef UART_HEX_CRLF_EN
    end else if (vidx == 5'd17) begin
      char_byte = 8'h0d;
`endif
    end
  end

  assign tx_valid_w = (count_q != '0);
  assign full       = (count_q == FULL_CNT);
  assign pop        = tx_valid_w && tx.tx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sel_d   = sel_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rdata_snd_start) begin
          data_d  = rdata_snd;
          sel_d   = pc_print_sel;
          cnt_d   = 5'd0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (!full) begin
          push  = 1'b1;
          cnt_d = cnt_q + 5'd1;
          if (vidx == LAST_VIDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (count_q == '0) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (rdata_snd_start) begin
          data_d  = rdata_snd;
          sel_d   = pc_print_sel;
          cnt_d   = 5'd0;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A start arriving mid-record is dropped and flagged; clearing takes priority
  always_comb begin
    overrun_d = overrun_q;
    if (rdata_snd_start && (state_q == S_CONV || state_q == S_DRAIN)) overrun_d = 1'b1;
    if (clr_overrun) overrun_d = 1'b0;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      sel_q     <= 1'b0;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      overrun_q <= overrun_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= char_byte;
  end

  // Head byte is masked while empty so stale storage never reaches the port
  assign tx.tx_valid = tx_valid_w;
  assign tx.tx_data  = tx_valid_w ? mem_q[rd_ptr_q] : 8'h00;
  assign flushing_wq = (state_q == S_FLUSH);
  assign snd_busy    = (state_q != S_IDLE);
  assign overrun     = overrun_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_hex_sender.sv
// Directed bench for uart_hex_sender: byte order, latency, backpressure, overrun, reset.
// Honours UART_HEX_CRLF_EN when appending expected terminators.
`timescale 1ns/1ps
module tb_uart_hex_sender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] rdata;
  logic        sel;
  logic        clr;
  logic        flushing_wq;
  logic        snd_busy;
  logic        overrun;
  logic [1:0]  state_dbg;

  uart_hex_sender_if tx_if();

  uart_hex_sender #(.FIFO_AW(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdata_snd_start (start),
    .rdata_snd       (rdata),
    .pc_print_sel    (sel),
    .tx              (tx_if),
    .flushing_wq     (flushing_wq),
    .snd_busy        (snd_busy),
    .overrun         (overrun),
    .clr_overrun     (clr),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ready_mode = 0;  // 0: always ready, 1: toggle, 2: held low

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         flush_q[$];
  int         first_valid_cyc = -1;
  int         last_pop_cyc    = -1;
  int         stable_err      = 0;
  int         start_cyc       = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    tx_if.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_if.tx_ready = 1'b1;
        1:       tx_if.tx_ready = ~tx_if.tx_ready;
        default: tx_if.tx_ready = 1'b0;
      endcase
    end
  end

  // Sink model: records accepted bytes, flush pulses and head-byte stability
  initial begin
    logic       stall_pend;
    logic [7:0] stall_data;
    stall_pend = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_if.tx_valid === 1'b1) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stall_pend && tx_if.tx_data !== stall_data) stable_err++;
        if (tx_if.tx_ready === 1'b1) begin
          got_q.push_back(tx_if.tx_data);
          last_pop_cyc = cyc;
          stall_pend   = 1'b0;
        end else begin
          stall_pend = 1'b1;
          stall_data = tx_if.tx_data;
        end
      end else begin
        stall_pend = 1'b0;
      end
      if (flushing_wq === 1'b1) flush_q.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    got_q.delete();
    flush_q.delete();
    first_valid_cyc = -1;
    last_pop_cyc    = -1;
    stable_err      = 0;
  endtask

  function automatic void add_exp(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef UART_HEX_CRLF_EN
    exp_q.push_back(8'h0d);
`endif
    exp_q.push_back(8'h0a);
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; rdata = '0; sel = 1'b0; clr = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
  endtask

  task automatic send_start(input logic [63:0] d, input logic s);
    @(posedge clk);
    #1;
    start = 1'b1; rdata = d; sel = s; start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0; rdata = '0; sel = 1'b0;
  endtask

  task automatic wait_flush(input int n, output bit to);
    int k;
    k = 0;
    while (flush_q.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    to = (flush_q.size() < n);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rdata = '0; sel = 1'b0; clr = 1'b0;
    ready_mode = 0;
    #1;
    checks++; if (tx_if.tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid got=%b exp=0", tx_if.tx_valid); end
    checks++; if (tx_if.tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h exp=00", tx_if.tx_data); end
    checks++; if (flushing_wq !== 1'b0) begin failures++; $display("FAIL rst_flushing got=%b exp=0", flushing_wq); end
    checks++; if (snd_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", snd_busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
    apply_reset();
  endtask

  task automatic test_record64();
    bit to;
    int d;
    clear_mon();
    exp_q.delete();
    add_exp("01234567 89abcdef");
    send_start(64'h0123_4567_89AB_CDEF, 1'b0);
    wait_flush(1, to);
    checks++; if (to) begin failures++; $display("FAIL rec64_timeout got=no_flush exp=flush"); end
    checks++; if (first_valid_cyc !== start_cyc + 2) begin failures++; $display("FAIL rec64_first_valid got=%0d exp=%0d", first_valid_cyc, start_cyc + 2); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rec64_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d != -1) begin failures++; $display("FAIL rec64_bytes idx=%0d got=%h exp=%h", d, got_q[d], exp_q[d]); end
    checks++; if (flush_q.size() !== 1) begin failures++; $display("FAIL rec64_flush_count got=%0d exp=1", flush_q.size()); end
    if (flush_q.size() > 0) begin
      checks++; if (flush_q[0] !== last_pop_cyc + 2) begin failures++; $display("FAIL rec64_flush_time got=%0d exp=%0d", flush_q[0], last_pop_cyc + 2); end
    end
    checks++; if (snd_busy !== 1'b0) begin failures++; $display("FAIL rec64_idle_after got=%b exp=0", snd_busy); end
  endtask

  task automatic test_record32();
    bit to;
    int d;
    clear_mon();
    exp_q.delete();
    add_exp("00001f00");
    send_start(64'hFFFF_FFFF_0000_1F00, 1'b1);
    wait_flush(1, to);
    checks++; if (to) begin failures++; $display("FAIL rec32_timeout got=no_flush exp=flush"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rec32_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d != -1) begin failures++; $display("FAIL rec32_bytes idx=%0d got=%h exp=%h", d, got_q[d], exp_q[d]); end
  endtask

  task automatic test_backpressure();
    bit to;
    int d;
    clear_mon();
    exp_q.delete();
    add_exp("deadbeef cafef00d");
    ready_mode = 2;
    send_start(64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    checks++; if (state_dbg !== 2'd2) begin failures++; $display("FAIL bp_hold_state got=%0d exp=2", state_dbg); end
    checks++; if (tx_if.tx_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b exp=1", tx_if.tx_valid); end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL bp_hold_popped got=%0d exp=0", got_q.size()); end
    ready_mode = 1;
    wait_flush(1, to);
    ready_mode = 0;
    checks++; if (to) begin failures++; $display("FAIL bp_timeout got=no_flush exp=flush"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL bp_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d != -1) begin failures++; $display("FAIL bp_bytes idx=%0d got=%h exp=%h", d, got_q[d], exp_q[d]); end
    checks++; if (stable_err !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stable_err); end
  endtask

  task automatic test_overrun();
    bit to;
    int d;
    clear_mon();
    exp_q.delete();
    add_exp("01234567 89abcdef");
    send_start(64'h0123_4567_89AB_CDEF, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF; sel = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; rdata = '0; sel = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    wait_flush(1, to);
    checks++; if (to) begin failures++; $display("FAIL ovr_timeout got=no_flush exp=flush"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL ovr_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d != -1) begin failures++; $display("FAIL ovr_bytes idx=%0d got=%h exp=%h", d, got_q[d], exp_q[d]); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    clr = 1'b1;
    #1;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_before_clr_edge got=%b exp=1", overrun); end
    @(posedge clk);
    #1;
    clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", overrun); end

    // clear arriving with a fresh overrun keeps the flag low
    clear_mon();
    exp_q.delete();
    add_exp("12345678");
    send_start(64'h0000_0000_1234_5678, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1; clr = 1'b1; rdata = 64'hABCD_ABCD_ABCD_ABCD; sel = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0; clr = 1'b0; rdata = '0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr_wins got=%b exp=0", overrun); end
    wait_flush(1, to);
    checks++; if (to) begin failures++; $display("FAIL ovr2_timeout got=no_flush exp=flush"); end
    d = first_diff();
    checks++; if (d != -1 || got_q.size() !== exp_q.size()) begin failures++; $display("FAIL ovr2_bytes got_len=%0d exp_len=%0d idx=%0d", got_q.size(), exp_q.size(), d); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int d;
    int k;
    clear_mon();
    exp_q.delete();
    add_exp("01234567 89abcdef");
    add_exp("00000000 00000001");
    send_start(64'h0123_4567_89AB_CDEF, 1'b0);
    k = 0;
    while (flushing_wq !== 1'b1 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b1; rdata = 64'h1; sel = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0; rdata = '0;
    wait_flush(2, to);
    checks++; if (to) begin failures++; $display("FAIL b2b_timeout got=%0d_flushes exp=2", flush_q.size()); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d != -1) begin failures++; $display("FAIL b2b_bytes idx=%0d got=%h exp=%h", d, got_q[d], exp_q[d]); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int d;
    clear_mon();
    ready_mode = 2;
    send_start(64'h0123_4567_89AB_CDEF, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (tx_if.tx_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid got=%b exp=1", tx_if.tx_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_if.tx_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", tx_if.tx_valid); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL rmid_state got=%0d exp=0", state_dbg); end
    checks++; if (snd_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", snd_busy); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (flush_q.size() !== 0 || got_q.size() !== 0) begin failures++; $display("FAIL rmid_no_output got_flush=%0d got_bytes=%0d exp=0", flush_q.size(), got_q.size()); end
    clear_mon();
    exp_q.delete();
    add_exp("00000000 00000001");
    send_start(64'h1, 1'b0);
    wait_flush(1, to);
    checks++; if (to) begin failures++; $display("FAIL rpost_timeout got=no_flush exp=flush"); end
    d = first_diff();
    checks++; if (d != -1 || got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rpost_bytes got_len=%0d exp_len=%0d idx=%0d", got_q.size(), exp_q.size(), d); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_record64();
    test_record32();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
